mul_seq: RTL

- Sequential radix-2 shift-add multiplier.
- It is the inverse counterpart of the combinational restoring divider in the synthesis library: it multiplies where the divider divides.
- It trades area for latency: one adder is reused for M cycles instead of an array of M adders.
- Intended for sequential garbled-circuit netlists. Timing is data-independent: always exactly M iterations, no early exit.

---
 rtl/mul_seq_pkg.sv | 25 ++
 rtl/mul_seq_add.sv | 14 +
 rtl/mul_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the mul_seq sequential shift-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // The counter must be able to hold every value 0..m.
  function automatic int cnt_width(input int m);
    return (clog2(m + 1) < 1) ? 1 : clog2(m + 1);
  endfunction

endpackage

// File: rtl/mul_seq_add.sv
// W-bit ripple adder with carry-in; the single accumulate adder reused by
// mul_seq on every iteration.
module mul_seq_add #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s
);

  assign s = a + b + W'(ci);

endmodule

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier: M data-independent iterations,
// one shared adder. Define MUL_SEQ_SIGNED_EN for two's-complement operands.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     A,
  input  logic [M-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   O
);

  localparam int CW = cnt_width(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  mcand;
  logic [M-1:0]  mplr;
  logic [N:0]    acc;
  logic [CW-1:0] cnt;

  logic          last;
  logic [N:0]    operand;
  logic          ci;
  logic          fill;
  logic [N:0]    sum;
  logic [N+M:0]  pair_shift;

  assign last = (cnt == LAST);

  // Operand selection for the accumulate step. The signed build treats the
  // multiplier MSB as negative weight, so the last partial product subtracts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    operand = '0;
    ci      = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
    if (mplr[0]) begin
      if (last) begin
        operand = ~{mcand[N-1], mcand};
        ci      = 1'b1;
      end else begin
        operand = {mcand[N-1], mcand};
      end
    end
`else
    if (mplr[0]) operand = {1'b0, mcand};
`endif
  end

  mul_seq_add #(.W(N + 1)) u_add (
    .a  (acc),
    .b  (operand),
    .ci (ci),
    .s  (sum)
  );

`ifdef MUL_SEQ_SIGNED_EN
  assign fill = sum[N];
`else
  assign fill = 1'b0;
`endif

  // {acc, mplr} after the one-bit right shift, as a single N+M+1 bit word.
  assign pair_shift = {fill, sum, mplr[M-1:0]} >> 1 | ({fill, {(N+M){1'b0}}});

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      O     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            mplr  <= B;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc  <= pair_shift[N+M:M];
          mplr <= pair_shift[M-1:0];
          cnt  <= cnt + CW'(1);
          if (last) O <= pair_shift[N+M-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
